// File: rtl/universal_counter_n.sv
// Parametrised N-bit universal counter: up/down, programmable limit, wrap or
// one-shot, synchronous clear/load, cascade carry and registered wrap/done flags.
module universal_counter_n #(
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             count,
  input  logic             cin,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             en;
  logic             down;
  logic             one_shot;
  logic             at_term;

  assign en       = count & cin;
  assign down     = mode[0];
  assign one_shot = mode[1];

  // Up counts treat anything at or above limit as terminal so q never runs past it
  assign at_term  = down ? (cnt_q == '0) : (cnt_q >= limit);
  assign tc       = en & at_term & ~done_q;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    done_d = done_q;
    if (sclr) begin
      cnt_d  = RESET_VAL;
      done_d = 1'b0;
    end else if (load) begin
      cnt_d  = din;
      done_d = 1'b0;
    end else if (en && !done_q) begin
      if (!at_term) begin
        cnt_d = down ? (cnt_q - WIDTH'(1)) : (cnt_q + WIDTH'(1));
      end else if (!one_shot) begin
        cnt_d  = down ? limit : '0;
        wrap_d = 1'b1;
      end else begin
        done_d = 1'b1;
        wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cnt_q  <= RESET_VAL;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

  assign q    = cnt_q;
  assign wrap = wrap_q;
  assign done = done_q;

endmodule

// File: doc/universal_counter_n.md
Name: universal_counter_n

Overview:
- Parametrised N-bit universal binary counter. Successor to the team's 4-bit load/count counter.
- Adds up/down direction, a programmable terminal limit, and wrap or one-shot (stop-at-terminal) modes.
- Adds synchronous clear, a cascade carry-in, and a registered wrap pulse and sticky done flag.
- Used as a timer/prescaler/event counter. Instances chain via cin/tc to build wider counters.

Parameters:
- WIDTH, 8, counter width in bits (legal 2..32).
- RESET_VAL, 0, value q takes on clear and sclr (WIDTH bits).

Ports:
- clk  in  1  rising-edge clock
- clear  in  1  asynchronous active-low reset
- sclr  in  1  synchronous clear, active high
- load  in  1  synchronous parallel load, active high
- din  in  WIDTH  load data
- count  in  1  count enable
- cin  in  1  cascade enable; tie 1 for standalone use
- mode  in  2  bit0 = direction (0 up, 1 down); bit1 = one-shot (1) or wrap (0)
- limit  in  WIDTH  terminal value for up count; reload value for down wrap
- q  out  WIDTH  counter value (registered)
- tc  out  1  terminal-count carry (combinational)
- wrap  out  1  registered one-cycle pulse on each wrap/terminal event
- done  out  1  sticky, registered; one-shot reached terminal

Behaviour:
- Reset (clear=0, asynchronous): q=RESET_VAL, wrap=0, done=0. This overrides all other inputs at any time, including mid-count.
- Definitions:
  - en = count & cin.
  - at_term: in up mode, q>=limit; in down mode, q==0.
  - tc = en & at_term & ~done. It is purely combinational so the next stage sees it in the same cycle.
- Per-edge priority, highest first:
  1. sclr: q=RESET_VAL, done=0, wrap=0.
  2. load: q=din, done=0, wrap=0. load wins over count in the same cycle.
  3. en & ~done & ~at_term: q=q+1 (up) or q-1 (down), wrap=0.
  4. en & ~done & at_term & wrap mode: q=0 (up) or q=limit (down), wrap=1.
  5. en & ~done & at_term & one-shot mode: q holds, done=1, wrap=1.
  6. Otherwise: q holds, wrap=0, done holds.
- Counting latency: q updates on the edge after en is sampled high. wrap and done assert in the same edge as the terminal transition.
- A wrap-mode up cycle has limit+1 states (0..limit). A down cycle has limit+1 states (limit..0).
- done=1 freezes q regardless of en. Only sclr, load or clear release it. While done=1, tc=0.
- A value loaded above limit in up mode counts as at_term: the next enabled edge wraps to 0 (wrap mode) or stops (one-shot). The counter never runs past limit.
- limit=0:
  - Up: every enabled edge is terminal; q stays 0 and wrap pulses each edge.
  - Down wrap: q stays 0 and wraps each edge.
- limit and mode are used combinationally every cycle; changes take effect on the next edge. Changing mode while done=1 does not clear done.
- Arithmetic is WIDTH-bit unsigned. No intermediate value ever exceeds WIDTH bits because the at_term check precedes the increment. limit = all-ones gives a full natural binary counter.
- Cascading: stage k's cin is driven from stage k-1's tc; count is shared across stages. All stages use wrap mode and the same direction.
- No X propagation: all flops have a reset value. Nothing depends on din or limit being valid while load=0 or en=0, respectively.

Test Plan:
- WIDTH=4, limit=9, up wrap, count=cin=1 for 12 edges from reset:
  - q goes 0..9,0,1.
  - tc is high only while q=9.
  - wrap pulses once, in the cycle after q=9.
- Down one-shot, load din=3, then count for 6 edges:
  - q goes 3,2,1,0 and then holds 0.
  - done=1 from the edge that leaves 0 and stays sticky; wrap pulses once.
  - A subsequent load of 5 clears done and gives q=5.
- Simultaneous controls: load=1, count=1, din=6 gives q=6, not 7. sclr=1 with load=1 gives q=RESET_VAL.
- Out-of-range load: limit=4, up wrap, load din=12, count one edge -> q=0 and wrap=1.
- Async reset: assert clear=0 between clock edges while q=7 and en=1 -> q=0, done=0 and wrap=0 immediately. Deassert clear -> counting resumes from 0 on the next enabled edge.
- Cascade: two WIDTH=4 instances, limit=15, up wrap, stage 1 cin driven from stage 0 tc, 300 edges -> the concatenated {q1,q0} equals the edge count mod 256 at every cycle.
